hazard_unit: RTL and testbench

- Pipeline control block for the 5-stage RISC-V core (F/D/E/M/W).
- Keeps its own shadow copy of destination/source register info as it moves D→E→M→W.
- From that state it drives:
  - operand forwarding selects for Execute;
  - F/D stalls for load-use hazards;
  - D/E flushes for taken branches and jumps.
- Keeps saturating stall and flush event counters for bring-up and debug.

---
 rtl/hazard_unit.sv | 107 ++++++++++
 tb/tb_hazard_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard control for the 5-stage core: shadows register usage through
// E/M/W and derives forwarding selects, load-use stalls, redirect flushes and event counters.
module hazard_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1D,
    input  logic [ADDR_WIDTH-1:0] rs2D,
    input  logic [ADDR_WIDTH-1:0] rdD,
    input  logic                  regwriteD,
    input  logic                  resultsrcD,
    input  logic                  pcsrcE,
    output logic [1:0]            forwardAE,
    output logic [1:0]            forwardBE,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  flushD,
    output logic                  flushE,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic [CNT_WIDTH-1:0]  flush_count
);

    logic [ADDR_WIDTH-1:0] rs1E, rs2E, rdE, rdM, rdW;
    logic                  regwriteE, loadE, regwriteM, regwriteW;
    logic                  lw, lwstall;
    logic [1:0]            fwd_a, fwd_b;

    // A redirect discards the Decode instruction, so it overrides the load-use stall.
    always_comb begin
        lw      = loadE & regwriteE & (rdE != '0) & ((rdE == rs1D) | (rdE == rs2D));
        lwstall = lw & ~pcsrcE;
    end

    always_comb begin
        fwd_a = 2'b00;
        if (regwriteM && rdM != '0 && rdM == rs1E)
            fwd_a = 2'b10;
        else if (regwriteW && rdW != '0 && rdW == rs1E)
            fwd_a = 2'b01;
    end

    always_comb begin
        fwd_b = 2'b00;
        if (regwriteM && rdM != '0 && rdM == rs2E)
            fwd_b = 2'b10;
        else if (regwriteW && rdW != '0 && rdW == rs2E)
            fwd_b = 2'b01;
    end

    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        stallF    = 1'b0;
        stallD    = 1'b0;
        flushD    = 1'b1;
        flushE    = 1'b1;
        if (rst) begin
            forwardAE = fwd_a;
            forwardBE = fwd_b;
            stallF    = lwstall;
            stallD    = lwstall;
            flushD    = pcsrcE;
            flushE    = lwstall | pcsrcE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rs1E        <= '0;
            rs2E        <= '0;
            rdE         <= '0;
            regwriteE   <= 1'b0;
            loadE       <= 1'b0;
            rdM         <= '0;
            regwriteM   <= 1'b0;
            rdW         <= '0;
            regwriteW   <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (flushE) begin
                rs1E      <= '0;
                rs2E      <= '0;
                rdE       <= '0;
                regwriteE <= 1'b0;
                loadE     <= 1'b0;
            end else begin
                rs1E      <= rs1D;
                rs2E      <= rs2D;
                rdE       <= rdD;
                regwriteE <= regwriteD;
                loadE     <= resultsrcD;
            end
            rdM       <= rdE;
            regwriteM <= regwriteE;
            rdW       <= rdM;
            regwriteW <= regwriteM;
            if (lwstall && stall_count != '1)
                stall_count <= stall_count + CNT_WIDTH'(1);
            if (pcsrcE && flush_count != '1)
                flush_count <= flush_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: stimulus pushes model expectations, a monitor pops and compares.
module tb_hazard_unit;

    localparam int AW = 5;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1D, rs2D, rdD;
    logic          regwriteD, resultsrcD, pcsrcE;
    logic [1:0]    forwardAE, forwardBE;
    logic          stallF, stallD, flushD, flushE;
    logic [CW-1:0] stall_count, flush_count;

    hazard_unit #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
        .regwriteD(regwriteD), .resultsrcD(resultsrcD), .pcsrcE(pcsrcE),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .stallF(stallF), .stallD(stallD),
        .flushD(flushD), .flushE(flushE), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rs1, rs2, rd;
        bit wr, ld;
    } ins_t;

    typedef struct {
        int fa, fb, stall, fd, fe, sc, fc;
    } exp_t;

    ins_t pipe[3];   // index 0 = Execute, 1 = Memory, 2 = Writeback
    int   scnt, fcnt;
    exp_t sb[$];
    int   checks = 0, passed = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    function automatic ins_t bubble();
        ins_t b;
        b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.wr = 0; b.ld = 0;
        return b;
    endfunction

    // Youngest in-flight writer of a nonzero register supplies the operand.
    function automatic int src_sel(input int r);
        if (r == 0) return 0;
        if (pipe[1].wr && pipe[1].rd == r) return 2;
        if (pipe[2].wr && pipe[2].rd == r) return 1;
        return 0;
    endfunction

    task automatic issue(input int r1, input int r2, input int rd, input bit wr,
                         input bit ld, input bit pc, input bit rs);
        exp_t e;
        ins_t d;
        bit   hz;
        rs1D = AW'(r1); rs2D = AW'(r2); rdD = AW'(rd);
        regwriteD = wr; resultsrcD = ld; pcsrcE = pc; rst = rs;
        d.rs1 = r1; d.rs2 = r2; d.rd = rd; d.wr = wr; d.ld = ld;
        hz = pipe[0].ld && pipe[0].wr && pipe[0].rd != 0 &&
             (pipe[0].rd == r1 || pipe[0].rd == r2) && !pc;
        e.sc = scnt; e.fc = fcnt;
        if (!rs) begin
            e.fa = 0; e.fb = 0; e.stall = 0; e.fd = 1; e.fe = 1;
        end else begin
            e.fa = src_sel(pipe[0].rs1);
            e.fb = src_sel(pipe[0].rs2);
            e.stall = int'(hz);
            e.fd = int'(pc);
            e.fe = int'(hz || pc);
        end
        sb.push_back(e);
        @(posedge clk);
        if (!rs) begin
            pipe[0] = bubble(); pipe[1] = bubble(); pipe[2] = bubble();
            scnt = 0; fcnt = 0;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (hz || pc) ? bubble() : d;
            if (hz) scnt = (scnt < CMAX) ? scnt + 1 : CMAX;
            if (pc) fcnt = (fcnt < CMAX) ? fcnt + 1 : CMAX;
        end
        #1;
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("forwardAE", int'(forwardAE), e.fa);
                chk("forwardBE", int'(forwardBE), e.fb);
                chk("stallF", int'(stallF), e.stall);
                chk("stallD", int'(stallD), e.stall);
                chk("flushD", int'(flushD), e.fd);
                chk("flushE", int'(flushE), e.fe);
                chk("stall_count", int'(stall_count), e.sc);
                chk("flush_count", int'(flush_count), e.fc);
            end
        end
    end

    initial begin : stim
        int budget;
        rst = 1'b0; rs1D = '0; rs2D = '0; rdD = 5'd5;
        regwriteD = 1'b1; resultsrcD = 1'b0; pcsrcE = 1'b0;
        @(posedge clk);
        pipe[0] = bubble(); pipe[1] = bubble(); pipe[2] = bubble();
        scnt = 0; fcnt = 0;
        #1;
        // reset hold with a live-looking decode instruction, then release
        issue(0, 0, 5, 1, 0, 0, 0);
        issue(0, 0, 5, 1, 0, 0, 0);
        issue(5, 5, 6, 1, 0, 0, 1);
        nop(); nop();
        // ALU to ALU, adjacent and with one instruction between
        issue(0, 0, 5, 1, 0, 0, 1);
        issue(5, 5, 6, 1, 0, 0, 1);
        nop(); nop();
        issue(0, 0, 5, 1, 0, 0, 1);
        issue(1, 2, 8, 1, 0, 0, 1);
        issue(5, 5, 9, 1, 0, 0, 1);
        nop(); nop(); nop();
        // M over W priority, then the same with x0
        issue(0, 0, 7, 1, 0, 0, 1);
        issue(0, 0, 7, 1, 0, 0, 1);
        issue(7, 7, 10, 1, 0, 0, 1);
        nop(); nop(); nop();
        issue(0, 0, 0, 1, 0, 0, 1);
        issue(0, 0, 0, 1, 0, 0, 1);
        issue(0, 0, 10, 1, 0, 0, 1);
        nop(); nop(); nop();
        // load-use: consumer re-presented while stalled
        issue(0, 0, 3, 1, 1, 0, 1);
        issue(0, 3, 11, 1, 0, 0, 1);
        issue(0, 3, 11, 1, 0, 0, 1);
        nop(); nop(); nop();
        // redirect alone, then redirect during load-use
        issue(1, 2, 4, 1, 0, 1, 1);
        nop();
        issue(0, 0, 3, 1, 1, 0, 1);
        issue(3, 0, 12, 1, 0, 1, 1);
        nop(); nop(); nop();
        // mid-operation reset discards in-flight state
        issue(0, 0, 6, 1, 0, 0, 1);
        issue(0, 0, 6, 1, 1, 0, 0);
        issue(6, 6, 1, 1, 0, 0, 1);
        nop(); nop();
        // counter saturation
        for (int i = 0; i < 40; i++) issue(3, 0, 3, 1, 1, 0, 1);
        nop();
        @(negedge clk);
        chk("stall_sat", int'(stall_count), CMAX);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) issue(0, 0, 0, 0, 0, 1, 1);
        // randomized traffic over a small register set
        for (int i = 0; i < 400; i++)
            issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 39) != 0);
        budget = 0;
        while (sb.size() != 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);
        #20;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
